// File: rtl/mem_responder_pkg.sv
// Shared command/state encodings and default I/O addresses for the CPU memory
// interface, used by the responder, its interface and the requester side.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10,
    MRSVD  = 2'b11
  } mem_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [8:0] LED_ADDR_DEF = 9'h100;
  localparam logic [8:0] SW_ADDR_DEF  = 9'h140;

  // The reserved encoding is deliberately not an access.
  function automatic logic is_access(mem_cmd_t cmd);
    return (cmd == MREAD) || (cmd == MWRITE);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU memory bus: request (cmd/addr/wdata) from the master, registered load
// data plus ready/error strobes back from the slave.
interface mem_responder_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  import mem_responder_pkg::*;

  mem_cmd_t            mem_cmd;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   write_data;
  logic [DATA_W-1:0]   read_data;
  logic                mem_ready;
  logic                bus_err;

  modport master (
    output mem_cmd, mem_addr, write_data,
    input  read_data, mem_ready, bus_err
  );

  modport slave (
    input  mem_cmd, mem_addr, write_data,
    output read_data, mem_ready, bus_err
  );

endinterface

// File: rtl/mem_responder_ram_1p.sv
// Single-port RAM: synchronous write, combinational (asynchronous) read.
// Contents are never reset.
module mem_responder_ram_1p #(
  parameter int DEPTH     = 256,
  parameter int WIDTH     = 16,
  parameter int AW        = $clog2(DEPTH),
  parameter     INIT_FILE = ""
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time into a data RAM, an LED register
// and a synchronized switch port, with programmable wait states and a ready strobe.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int              DATA_W      = 16,
  parameter int              ADDR_W      = 9,
  parameter int              RAM_DEPTH   = 256,
  parameter int              WAIT_CYCLES = 0,
  parameter logic [ADDR_W-1:0] LED_ADDR  = LED_ADDR_DEF,
  parameter logic [ADDR_W-1:0] SW_ADDR   = SW_ADDR_DEF,
  parameter                  INIT_FILE   = "data.txt"
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_responder_if.slave       bus,
  input  logic [7:0]           i_sw,
  output logic [7:0]           o_leds
);

  localparam int RIDX_W = $clog2(RAM_DEPTH);
  localparam int CNT_W  = 4;

  state_t              r_state;
  state_t              w_next;
  logic                w_accept;
  mem_cmd_t            r_cmd;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_rdata;
  logic [7:0]          r_leds;
  logic [7:0]          r_sw_meta;
  logic [7:0]          r_sw_sync;

  logic                w_access;
  logic                w_is_ram;
  logic                w_is_led;
  logic                w_is_sw;
  logic                w_unmapped;
  logic                w_ram_we;
  logic [DATA_W-1:0]   w_ram_rdata;
  logic [DATA_W-1:0]   w_load;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE: begin
        if (is_access(bus.mem_cmd)) begin
          w_accept = 1'b1;
          w_next   = BUSY;
        end
      end
      BUSY:    if (r_cnt == '0) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The access commits on the BUSY->DONE edge, from latched request values only.
  assign w_access = (r_state == BUSY) && (r_cnt == '0);

  // ------------------------------------------------------ request latches
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_cmd   <= bus.mem_cmd;
      r_addr  <= bus.mem_addr;
      r_wdata <= bus.write_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             r_cnt <= '0;
    else if (w_accept)     r_cnt <= CNT_W'(WAIT_CYCLES);
    else if (r_state == BUSY && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  // ------------------------------------------------------ address decode
  assign w_is_ram   = ~r_addr[ADDR_W-1];
  assign w_is_led   = (r_addr == LED_ADDR);
  assign w_is_sw    = (r_addr == SW_ADDR);
  assign w_unmapped = ~(w_is_ram | w_is_led | w_is_sw);
  assign w_ram_we   = w_access && (r_cmd == MWRITE) && w_is_ram;

  mem_responder_ram_1p #(
    .DEPTH     (RAM_DEPTH),
    .WIDTH     (DATA_W),
    .AW        (RIDX_W),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_ram_we),
    .i_addr  (r_addr[RIDX_W-1:0]),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_comb begin
    w_load = '0;
    if (w_is_ram)      w_load = w_ram_rdata;
    else if (w_is_led) w_load = {{(DATA_W-8){1'b0}}, r_leds};
    else if (w_is_sw)  w_load = {{(DATA_W-8){1'b0}}, r_sw_sync};
  end

  // ------------------------------------------------- registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
      r_leds  <= '0;
    end else if (w_access) begin
      if (r_cmd == MREAD)                 r_rdata <= w_load;
      if (r_cmd == MWRITE && w_is_led)    r_leds  <= r_wdata[7:0];
    end
  end

  // Switches are asynchronous to clk; reads only ever see the second stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= i_sw;
      r_sw_sync <= r_sw_meta;
    end
  end

  assign bus.read_data = r_rdata;
  assign bus.mem_ready = (r_state == DONE);
  assign bus.bus_err   = (r_state == DONE) && w_unmapped;
  assign o_leds        = r_leds;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: two responders (0 and 3 wait states) driven by directed and
// random requests, checked against a word-level model of RAM, LEDs and switches.
module tb_mem_responder;
  import mem_responder_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sw;
  logic [7:0] leds0, leds3;

  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_W(9), .DATA_W(16)) if0 ();
  mem_responder_if #(.ADDR_W(9), .DATA_W(16)) ifw ();

  mem_responder #(.WAIT_CYCLES(0), .INIT_FILE("")) u_dut0 (
    .clk(clk), .reset(reset), .bus(if0), .i_sw(sw), .o_leds(leds0));

  mem_responder #(.WAIT_CYCLES(3), .INIT_FILE("")) u_dut3 (
    .clk(clk), .reset(reset), .bus(ifw), .i_sw(sw), .o_leds(leds3));

  typedef struct {
    logic [15:0] rd;
    bit          rd_known;
    bit          err;
    logic [7:0]  leds;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];
  exp_t e0, e3;

  int checks = 0;
  int errors = 0;

  // Reference model, one copy per DUT
  logic [15:0] m_ram   [2][256];
  bit          m_known [2][256];
  logic [7:0]  m_leds  [2];
  logic [15:0] m_rd    [2];
  bit          m_rd_known [2];

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_leds[d]     = 8'h00;
      m_rd[d]       = 16'h0000;
      m_rd_known[d] = 1'b1;
    end
  endtask

  task automatic model_req(int d, mem_cmd_t c, logic [8:0] a, logic [15:0] wd, output exp_t e);
    bit err = 1'b0;
    if (a < 9'h100) begin
      if (c == MWRITE) begin
        m_ram[d][a[7:0]]   = wd;
        m_known[d][a[7:0]] = 1'b1;
      end else begin
        m_rd[d]       = m_ram[d][a[7:0]];
        m_rd_known[d] = m_known[d][a[7:0]];
      end
    end else if (a == 9'h100) begin
      if (c == MWRITE) m_leds[d] = wd[7:0];
      else begin m_rd[d] = {8'h00, m_leds[d]}; m_rd_known[d] = 1'b1; end
    end else if (a == 9'h140) begin
      if (c == MREAD) begin m_rd[d] = {8'h00, sw}; m_rd_known[d] = 1'b1; end
    end else begin
      err = 1'b1;
      if (c == MREAD) begin m_rd[d] = 16'h0000; m_rd_known[d] = 1'b1; end
    end
    e.rd       = m_rd[d];
    e.rd_known = m_rd_known[d];
    e.err      = err;
    e.leds     = m_leds[d];
  endtask

  task automatic drive(int d, mem_cmd_t c, logic [8:0] a, logic [15:0] wd);
    if (d == 0) begin
      if0.mem_cmd = c; if0.mem_addr = a; if0.write_data = wd;
    end else begin
      ifw.mem_cmd = c; ifw.mem_addr = a; ifw.write_data = wd;
    end
  endtask

  function automatic logic rdy(int d);
    return (d == 0) ? if0.mem_ready : ifw.mem_ready;
  endfunction

  // Called just after a rising edge; returns just after a rising edge.
  task automatic do_req(int d, mem_cmd_t c, logic [8:0] a, logic [15:0] wd);
    exp_t e;
    int   lat = 0;
    model_req(d, c, a, wd, e);
    if (d == 0) q0.push_back(e); else q3.push_back(e);
    drive(d, c, a, wd);
    do begin
      @(negedge clk);
      lat++;
    end while (!rdy(d) && lat < 60);
    chk((d == 0) ? "latency_w0" : "latency_w3", lat, (d == 0) ? 3 : 6);
    @(posedge clk); #1;
    drive(d, MNONE, 9'h000, 16'h0000);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic apply_reset_async();
    @(negedge clk); #2;
    reset = 1'b1;
    drive(0, MNONE, 9'h000, 16'h0000);
    drive(1, MNONE, 9'h000, 16'h0000);
    #1;
    chk("rst_rdata0", if0.read_data, 16'h0000);
    chk("rst_leds0",  leds0,         8'h00);
    chk("rst_ready0", if0.mem_ready, 1'b0);
    chk("rst_rdata3", ifw.read_data, 16'h0000);
    chk("rst_leds3",  leds3,         8'h00);
    chk("rst_ready3", ifw.mem_ready, 1'b0);
    model_reset();
    q0.delete();
    q3.delete();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic set_sw(logic [7:0] v);
    sw = v;
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] rand_addr();
    int r = $urandom_range(0, 9);
    if (r <= 4)      return 9'($urandom_range(0, 15));
    else if (r == 5) return {1'b0, 8'($urandom)};
    else if (r == 6) return 9'h100;
    else if (r == 7) return 9'h140;
    else             return {1'b1, 8'($urandom)};
  endfunction

  // Scoreboard monitors
  always @(negedge clk) begin
    if (!reset) begin
      if (if0.mem_ready) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ready0 actual=1 required=0");
        end else begin
          e0 = q0.pop_front();
          chk("bus_err0", if0.bus_err, e0.err);
          if (e0.rd_known) chk("read_data0", if0.read_data, e0.rd);
          chk("leds0", leds0, e0.leds);
        end
      end else begin
        chk("err_idle0", if0.bus_err, 1'b0);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (ifw.mem_ready) begin
        if (q3.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ready3 actual=1 required=0");
        end else begin
          e3 = q3.pop_front();
          chk("bus_err3", ifw.bus_err, e3.err);
          if (e3.rd_known) chk("read_data3", ifw.read_data, e3.rd);
          chk("leds3", leds3, e3.leds);
        end
      end else begin
        chk("err_idle3", ifw.bus_err, 1'b0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1;
    sw    = 8'h00;
    drive(0, MNONE, 9'h000, 16'h0000);
    drive(1, MNONE, 9'h000, 16'h0000);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) m_known[d][i] = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("init_rdata", if0.read_data, 16'h0000);
    chk("init_ready", if0.mem_ready, 1'b0);
    chk("init_err",   if0.bus_err,   1'b0);
    chk("init_leds",  leds0,         8'h00);
    reset = 1'b0;
    @(posedge clk); #1;

    // RAM write/read round trip, LED register, switch port, unmapped address
    do_req(0, MWRITE, 9'h005, 16'hABCD);
    do_req(0, MREAD,  9'h005, 16'h0000);
    do_req(0, MWRITE, 9'h100, 16'h12A5);
    do_req(0, MREAD,  9'h100, 16'h0000);
    set_sw(8'h3C);
    do_req(0, MREAD,  9'h140, 16'h0000);
    do_req(0, MWRITE, 9'h140, 16'hFFFF);
    do_req(0, MREAD,  9'h1FF, 16'h0000);
    do_req(0, MWRITE, 9'h1FF, 16'h7777);

    // Reserved command encoding must be ignored
    drive(0, MRSVD, 9'h005, 16'h1111);
    repeat (5) @(posedge clk);
    #1;
    chk("rsvd_no_ready", if0.mem_ready, 1'b0);
    drive(0, MNONE, 9'h000, 16'h0000);
    do_req(0, MREAD, 9'h005, 16'h0000);

    // Async reset with nonzero read_data and leds; RAM survives reset
    apply_reset_async();
    do_req(0, MREAD, 9'h005, 16'h0000);

    // Randomized traffic on the zero-wait responder
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 19) == 0) set_sw(8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      do_req(0, ($urandom_range(0, 1) == 1) ? MWRITE : MREAD, rand_addr(), 16'($urandom));
    end

    // Three wait states: latency, then reset while BUSY aborts an uncommitted write
    do_req(1, MWRITE, 9'h010, 16'h5555);
    do_req(1, MREAD,  9'h010, 16'h0000);
    drive(1, MWRITE, 9'h010, 16'hDEAD);
    @(posedge clk); #1;
    apply_reset_async();
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_ready", ifw.mem_ready, 1'b0);
    do_req(1, MREAD, 9'h010, 16'h0000);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) set_sw(8'($urandom));
      do_req(1, ($urandom_range(0, 1) == 1) ? MWRITE : MREAD, rand_addr(), 16'($urandom));
    end

    repeat (4) @(posedge clk);
    #1;
    chk("q0_drained", q0.size(), 0);
    chk("q3_drained", q3.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
